// File: rtl/ripple_add_sequencer.sv
// Nibble-serial ripple adder/subtractor: one 4-bit slice per cycle, LSB first, NIBBLES cycles per operation.
// Result is held in DONE until out_ready; in_ready is high only in IDLE, so there is no overlap between operations.
module ripple_add_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   cin,
   input  logic                   sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   cout,
   output logic                   ovf,
   output logic                   busy
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, b_q;
   logic            carry_q;
   logic [IW-1:0]   idx_q;
   logic [4:0]      slice_add;
   logic            last;
   logic            accept;

   assign slice_add = {1'b0, a_q[int'(idx_q)*4 +: 4]}
                    + {1'b0, b_q[int'(idx_q)*4 +: 4]}
                    + {4'b0, carry_q};
   assign last      = (idx_q == LAST_IDX);

   // in_ready is gated by rst_n so nothing is offered while reset is held
   assign in_ready  = rst_n && (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign accept    = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = ADD;
         ADD:     if (last)      state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  // subtraction is A + ~B + 1; cin is ignored
                  a_q     <= a;
                  b_q     <= sub ? ~b : b;
                  carry_q <= sub ? 1'b1 : cin;
                  idx_q   <= '0;
               end
            end
            ADD: begin
               sum[int'(idx_q)*4 +: 4] <= slice_add[3:0];
               carry_q                 <= slice_add[4];
               if (last) begin
                  cout <= slice_add[4];
                  ovf  <= (a_q[W-1] == b_q[W-1]) && (slice_add[3] != a_q[W-1]);
               end else begin
                  idx_q <= idx_q + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/ripple_add_sequencer.md
RIPPLE_ADD_SEQUENCER -- requirements
Module: ripple_add_sequencer

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices per operand; legal range 1..16.
REQ-002 Operand width W = 4*NIBBLES (16 at default).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  W  operand A.
REQ-008 b  input  W  operand B.
REQ-009 cin  input  1  carry-in; ignored when sub=1.
REQ-010 sub  input  1  0: A+B+cin; 1: A-B.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 sum  output  W  registered result.
REQ-014 cout  output  1  final carry; for sub, 1 = no borrow.
REQ-015 ovf  output  1  two's-complement signed overflow.
REQ-016 busy  output  1  high in ADD and DONE states.

Function
REQ-017 FSM states shall be IDLE, ADD, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE, both combinational decodes of state.
REQ-018 IDLE: on in_valid&&in_ready at a rising edge, capture a, b_eff = sub ? ~b : b, carry = sub ? 1 : cin, slice index = 0, next state ADD.
REQ-019 ADD: each cycle one 4-bit ripple add of slice idx: {c,s} = a[idx] + b_eff[idx] + carry; s written to sum slice idx, carry <= c, idx <= idx+1.
REQ-020 ADD shall last exactly NIBBLES cycles, least-significant slice first; after slice NIBBLES-1, next state DONE.
REQ-021 Latency: out_valid shall be high after the NIBBLES-th rising edge following the accept edge (4 edges at default); NIBBLES=1 gives 1 edge.
REQ-022 On entry to DONE: cout = final carry; ovf = (a[W-1]==b_eff[W-1]) && (sum[W-1]!=a[W-1]).
REQ-023 DONE: sum, cout, ovf shall be stable while out_valid=1 && out_ready=0, for any number of cycles.
REQ-024 DONE with out_ready=1 at a rising edge: next state IDLE; no same-cycle acceptance of new operands (in_ready=0 in DONE).
REQ-025 in_valid, a, b, cin, sub shall be ignored outside IDLE; captured operands shall not change during ADD.
REQ-026 sum, cout, ovf shall retain the last result in IDLE until the next completed operation overwrites them; partially written sum slices during ADD shall not be considered valid.
REQ-027 Slice index wraps to 0 only via new acceptance; no index value >= NIBBLES shall be used.

Reset
REQ-028 rst_n low shall immediately force state IDLE, sum=0, cout=0, ovf=0, carry=0, index=0, busy=0, out_valid=0.
REQ-029 in_ready shall be 0 while rst_n is low and 1 from the first cycle after release.
REQ-030 Reset during ADD or DONE shall abandon the operation; no out_valid for it after release.

Verification (NIBBLES=4)
REQ-031 a=0x0000, b=0x0000, cin=0, sub=0 -> out_valid after 4th edge post-accept, sum=0x0000, cout=0, ovf=0.
REQ-032 a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all four slices).
REQ-033 a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1; a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
REQ-034 Hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with a=0x1111 -> out_valid, sum unchanged, in_ready=0; raise out_ready -> IDLE next edge, in_ready=1.
REQ-035 Assert rst_n=0 two cycles into ADD -> out_valid=0, sum=0 immediately; after release, a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0.
REQ-036 Back-to-back: in_valid held high, out_ready held high -> one accept every NIBBLES+2 cycles, each result matching A+B+cin.
